// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter with configurable width, parity and stop bits
//
// Sends one frame per accepted word: a SYNC wait (line high) until the next
// baud edge, start bit (0), DATA_W data bits LSB first, an optional parity
// bit, then STOP_BITS stop periods (1). Every bit period is one rising edge
// of tick_i, which is treated as data and edge-detected in the clk_i domain.
//
// Ports:
//   clk_i    in   system clock
//   rst_ni   in   asynchronous active-low reset
//   tick_i   in   baud-rate square wave, synchronous to clk_i
//   data_i   in   DATA_W word to send, sampled on the accept cycle
//   valid_i  in   data_i is valid
//   ready_o  out  high while idle; accept = valid_i & ready_o
//   tx_o     out  registered serial line, idle high
//   busy_o   out  high from the accept until the last stop period ends
`timescale 1ns/1ps
module uart_tx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  // Value of the stop counter during the final stop period.
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic              tick_q;
  logic              bit_en;
  logic              accept;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] shifted;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              par_q, par_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  // One-cycle pulse per rising edge of the baud wave.
  assign bit_en  = tick_i & ~tick_q;
  assign ready_o = (state_q == S_IDLE);
  assign accept  = valid_i & ready_o;
  assign shifted = shreg_q >> 1;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      tick_q     <= 1'b0;
      shreg_q    <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_i;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    par_d      = par_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        // A bit_en coinciding with the accept is deliberately ignored:
        // SYNC only advances on a bit_en seen while already in SYNC.
        if (accept) begin
          shreg_d    = data_i;
          par_d      = (^data_i) ^ (PARITY_ODD != 0);
          stop_cnt_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (bit_en) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_en) begin
          tx_d    = shreg_q[0];
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_en) begin
          if (idx_q < IDX_LAST) begin
            shreg_d = shifted;
            idx_d   = idx_q + 1'b1;
            tx_d    = shifted[0];
          end else if (PARITY_EN != 0) begin
            tx_d    = par_q;
            state_d = S_PARITY;
          end else begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_en) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_en) begin
          if (stop_cnt_q == STOP_LAST) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
